// File: rtl/mem_stage_if.sv
// mem_stage_if: EX->MEM payload, data_sram response, WB handshake and the
// MEM->WB / MEM->ID buses of the memory-access stage, bundled as one interface.
interface mem_stage_if;
  // EX -> MEM
  logic        ex_mem_valid;
  logic        mem_allowin;
  logic        ex_req_sent;
  logic        ex_gr_we;
  logic        ex_res_from_mem;
  logic [2:0]  ex_mem_type;
  logic [1:0]  ex_addr_low2;
  logic [4:0]  ex_dest;
  logic [31:0] ex_pc;
  logic [31:0] ex_result;
  logic        ex_excp;
  logic        ex_ertn;
  // data_sram response
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  // WB side
  logic        wb_allowin;
  logic        wb_flush;
  logic        mem_wb_valid;
  logic [31:0] mem_wb_pc;
  logic        mem_wb_gr_we;
  logic [4:0]  mem_wb_dest;
  logic [31:0] mem_wb_result;
  logic        mem_wb_excp;
  logic        mem_wb_ertn;
  // hints back to EX / ID
  logic        mem_ex;
  logic        mem_ertn;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_dest;
  logic [31:0] mem_fwd_data;
  logic        mem_fwd_stall;

  modport master (
    output ex_mem_valid, ex_req_sent, ex_gr_we, ex_res_from_mem, ex_mem_type,
           ex_addr_low2, ex_dest, ex_pc, ex_result, ex_excp, ex_ertn,
           data_sram_data_ok, data_sram_rdata, wb_allowin, wb_flush,
    input  mem_allowin, mem_wb_valid, mem_wb_pc, mem_wb_gr_we, mem_wb_dest,
           mem_wb_result, mem_wb_excp, mem_wb_ertn, mem_ex, mem_ertn,
           mem_fwd_we, mem_fwd_dest, mem_fwd_data, mem_fwd_stall
  );

  modport slave (
    input  ex_mem_valid, ex_req_sent, ex_gr_we, ex_res_from_mem, ex_mem_type,
           ex_addr_low2, ex_dest, ex_pc, ex_result, ex_excp, ex_ertn,
           data_sram_data_ok, data_sram_rdata, wb_allowin, wb_flush,
    output mem_allowin, mem_wb_valid, mem_wb_pc, mem_wb_gr_we, mem_wb_dest,
           mem_wb_result, mem_wb_excp, mem_wb_ertn, mem_ex, mem_ertn,
           mem_fwd_we, mem_fwd_dest, mem_fwd_data, mem_fwd_stall
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Waits for the in-order data_sram response of a load, aligns and extends it,
// and silently absorbs responses that belong to instructions flushed by WB.
module mem_stage #(
  parameter int DISCARD_W = 2
) (
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave mem_io
);
  // state | meaning
  // IDLE  | empty, or holding an instr that needs no load data
  // WAIT  | instr issued a data_sram request, response not seen yet
  // HOLD  | response captured in data_buf_q while WB was not accepting
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  localparam int                   CNT_W       = DISCARD_W + 2;
  localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;

  state_t               state_q;
  logic                 valid_q;
  logic [31:0]          data_buf_q;
  logic [DISCARD_W-1:0] discard_cnt_q, discard_cnt_d;

  logic                 gr_we_q, res_from_mem_q, excp_q, ertn_q;
  logic [2:0]           mem_type_q;
  logic [1:0]           addr_low2_q;
  logic [4:0]           dest_q;
  logic [31:0]          pc_q, result_q;

  logic                 discard_empty, data_ok_attr, data_ok_discard;
  logic                 ready_go, allowin, accept;
  logic                 flush_wait, flush_incoming;
  logic [CNT_W-1:0]     cnt_sum;
  logic                 cnt_ovf;
  logic                 sext;
  logic [31:0]          load_raw, load_shift, load_aligned, final_result;
  logic                 fwd_we;

  // A response goes to the discard counter first; only with no discards
  // pending does it belong to the instruction currently in the stage.
  assign discard_empty   = (discard_cnt_q == '0);
  assign data_ok_attr    = mem_io.data_sram_data_ok & discard_empty;
  assign data_ok_discard = mem_io.data_sram_data_ok & ~discard_empty;

  assign ready_go = (state_q != S_WAIT) | data_ok_attr;
  assign allowin  = ~valid_q | (ready_go & mem_io.wb_allowin);
  assign accept   = mem_io.ex_mem_valid & allowin;

  // Requests whose owners die in a flush still get a response later.
  assign flush_wait     = mem_io.wb_flush & valid_q & (state_q == S_WAIT) & ~data_ok_attr;
  assign flush_incoming = mem_io.wb_flush & accept & mem_io.ex_req_sent;

  // Next value of the cancelled-response counter, saturating at its maximum.
  always_comb begin
    cnt_sum = CNT_W'(discard_cnt_q) + CNT_W'(flush_wait) + CNT_W'(flush_incoming)
            - CNT_W'(data_ok_discard);
    cnt_ovf = (cnt_sum > CNT_W'(DISCARD_MAX));
    discard_cnt_d = cnt_ovf ? DISCARD_MAX : cnt_sum[DISCARD_W-1:0];
  end

  // Load alignment and sign/zero extension; zero added latency.
  always_comb begin
    load_raw   = (state_q == S_HOLD) ? data_buf_q : mem_io.data_sram_rdata;
    load_shift = load_raw >> {addr_low2_q, 3'b000};
    sext       = ~mem_type_q[2];
    case (mem_type_q[1:0])
      2'b00:   load_aligned = {{24{sext & load_shift[7]}}, load_shift[7:0]};
      2'b01:   load_aligned = {{16{sext & load_shift[15]}}, load_shift[15:0]};
      default: load_aligned = load_shift;
    endcase
    final_result = res_from_mem_q ? load_aligned : result_q;
  end

  // Stage FSM: occupancy, wait-for-data and response buffering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q    <= 1'b0;
      state_q    <= S_IDLE;
      data_buf_q <= '0;
    end else if (mem_io.wb_flush) begin
      valid_q <= 1'b0;
      state_q <= S_IDLE;
    end else if (allowin) begin
      valid_q <= mem_io.ex_mem_valid;
      state_q <= (mem_io.ex_mem_valid & mem_io.ex_req_sent & ~mem_io.ex_excp) ? S_WAIT : S_IDLE;
    end else if ((state_q == S_WAIT) && data_ok_attr) begin
      data_buf_q <= mem_io.data_sram_rdata;
      state_q    <= S_HOLD;
    end
  end

  // Payload register, loaded on every EX->MEM handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      gr_we_q        <= 1'b0;
      res_from_mem_q <= 1'b0;
      excp_q         <= 1'b0;
      ertn_q         <= 1'b0;
      mem_type_q     <= '0;
      addr_low2_q    <= '0;
      dest_q         <= '0;
      pc_q           <= '0;
      result_q       <= '0;
    end else if (accept) begin
      gr_we_q        <= mem_io.ex_gr_we;
      res_from_mem_q <= mem_io.ex_res_from_mem;
      excp_q         <= mem_io.ex_excp;
      ertn_q         <= mem_io.ex_ertn;
      mem_type_q     <= mem_io.ex_mem_type;
      addr_low2_q    <= mem_io.ex_addr_low2;
      dest_q         <= mem_io.ex_dest;
      pc_q           <= mem_io.ex_pc;
      result_q       <= mem_io.ex_result;
    end
  end

  // Cancelled-response counter; reaching past its maximum is a sizing error.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      discard_cnt_q <= '0;
    end else begin
      assert (!cnt_ovf);
      discard_cnt_q <= discard_cnt_d;
    end
  end

  assign fwd_we = valid_q & gr_we_q & ~excp_q & (dest_q != 5'd0);

  assign mem_io.mem_allowin   = allowin;
  assign mem_io.mem_wb_valid  = valid_q & ready_go & ~mem_io.wb_flush;
  assign mem_io.mem_wb_pc     = pc_q;
  assign mem_io.mem_wb_gr_we  = gr_we_q;
  assign mem_io.mem_wb_dest   = dest_q;
  assign mem_io.mem_wb_result = final_result;
  assign mem_io.mem_wb_excp   = excp_q;
  assign mem_io.mem_wb_ertn   = ertn_q;
  assign mem_io.mem_ex        = valid_q & excp_q;
  assign mem_io.mem_ertn      = valid_q & ertn_q;
  assign mem_io.mem_fwd_we    = fwd_we;
  assign mem_io.mem_fwd_dest  = dest_q;
  assign mem_io.mem_fwd_data  = final_result;
  assign mem_io.mem_fwd_stall = fwd_we & res_from_mem_q & ~ready_go;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors for load alignment, hand-written multi-cycle
// sequences, and a randomized run against a transaction-level model.
module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_stage_if bus();
  mem_stage #(.DISCARD_W(2)) dut (.clk(clk), .resetn(resetn), .mem_io(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ld;
    logic [2:0]  typ;
    logic [1:0]  a;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        gr_we, res, req, excp, ertn;
    logic [2:0]  typ;
    logic [1:0]  a;
    logic [4:0]  dest;
    logic [31:0] pc, alu;
  } ins_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ex_mem_valid      = 1'b0;
    bus.ex_req_sent       = 1'b0;
    bus.ex_gr_we          = 1'b0;
    bus.ex_res_from_mem   = 1'b0;
    bus.ex_mem_type       = 3'b000;
    bus.ex_addr_low2      = 2'b00;
    bus.ex_dest           = 5'd0;
    bus.ex_pc             = 32'h0;
    bus.ex_result         = 32'h0;
    bus.ex_excp           = 1'b0;
    bus.ex_ertn           = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h0;
    bus.wb_allowin        = 1'b1;
    bus.wb_flush          = 1'b0;
  endtask

  task automatic drive_ins(input ins_t i, input logic v);
    bus.ex_mem_valid    = v;
    bus.ex_req_sent     = i.req;
    bus.ex_gr_we        = i.gr_we;
    bus.ex_res_from_mem = i.res;
    bus.ex_mem_type     = i.typ;
    bus.ex_addr_low2    = i.a;
    bus.ex_dest         = i.dest;
    bus.ex_pc           = i.pc;
    bus.ex_result       = i.alu;
    bus.ex_excp         = i.excp;
    bus.ex_ertn         = i.ertn;
  endtask

  function automatic ins_t mk_load(input logic [2:0] t, input logic [1:0] a,
                                   input logic [4:0] d, input logic [31:0] pc);
    ins_t i;
    i = '{gr_we: 1'b1, res: 1'b1, req: 1'b1, excp: 1'b0, ertn: 1'b0,
          typ: t, a: a, dest: d, pc: pc, alu: 32'h0};
    return i;
  endfunction

  function automatic ins_t mk_alu(input logic [4:0] d, input logic [31:0] pc, input logic [31:0] r);
    ins_t i;
    i = '{gr_we: 1'b1, res: 1'b0, req: 1'b0, excp: 1'b0, ertn: 1'b0,
          typ: 3'b011, a: 2'b00, dest: d, pc: pc, alu: r};
    return i;
  endfunction

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  // Reference load result: pick the addressed bytes arithmetically, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] t, input logic [1:0] a);
    longint x, v, span;
    int nbytes;
    nbytes = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
    x    = longint'({32'h0, d});
    span = longint'(1) << (8 * nbytes);
    v    = (x / (longint'(1) << (8 * int'(a)))) % span;
    if (!t[2] && nbytes < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  logic [31:0] gen_pc = 32'h1c00_0000;

  function automatic ins_t gen_ins();
    ins_t i;
    int kind;
    kind = $urandom_range(0, 9);
    gen_pc = gen_pc + 32'd4;
    i = mk_alu(5'($urandom_range(0, 31)), gen_pc, $urandom);
    i.gr_we = ($urandom_range(0, 7) != 0);
    if (kind >= 4 && kind <= 6) begin
      i.res = 1'b1; i.req = 1'b1; i.gr_we = 1'b1;
      case ($urandom_range(0, 2))
        0: begin i.typ = 3'b000; i.a = 2'($urandom_range(0, 3)); end
        1: begin i.typ = 3'b001; i.a = {1'($urandom_range(0, 1)), 1'b0}; end
        default: begin i.typ = 3'b011; i.a = 2'b00; end
      endcase
      if (i.typ != 3'b011) i.typ[2] = 1'($urandom_range(0, 1));
    end else if (kind == 7) begin
      i.req = 1'b1; i.gr_we = 1'b0;
    end else if (kind == 8) begin
      i.excp = 1'b1; i.res = 1'($urandom_range(0, 1));
    end else if (kind == 9) begin
      i.ertn = 1'b1; i.gr_we = 1'b0;
    end
    return i;
  endfunction

  vec_t vecs[10];

  initial begin
    ins_t        li;
    int          xfers;
    // model state
    bit          pend[$];
    logic        m_valid, m_need, m_have;
    logic [31:0] m_data;
    ins_t        m_ins, cur;
    logic        cur_v, last_taken, last_flush;
    logic        d_ok, flush, wba, resp_live, done, e_wbv, e_allow, e_fwe, e_stall;
    logic [31:0] rdata, ldata, e_res;

    vecs[0] = '{1'b1, 3'b000, 2'd2, 32'h0080_0000, 32'h0,         32'hFFFF_FF80};
    vecs[1] = '{1'b1, 3'b101, 2'd2, 32'hBEEF_1234, 32'h0,         32'h0000_BEEF};
    vecs[2] = '{1'b1, 3'b001, 2'd2, 32'hBEEF_1234, 32'h0,         32'hFFFF_BEEF};
    vecs[3] = '{1'b1, 3'b011, 2'd0, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 3'b100, 2'd3, 32'h9A00_0000, 32'h0,         32'h0000_009A};
    vecs[5] = '{1'b1, 3'b000, 2'd0, 32'h0000_007F, 32'h0,         32'h0000_007F};
    vecs[6] = '{1'b1, 3'b000, 2'd1, 32'h0000_F100, 32'h0,         32'hFFFF_FFF1};
    vecs[7] = '{1'b1, 3'b001, 2'd0, 32'h1234_8001, 32'h0,         32'hFFFF_8001};
    vecs[8] = '{1'b1, 3'b100, 2'd1, 32'h0000_F100, 32'h0,         32'h0000_00F1};
    vecs[9] = '{1'b0, 3'b000, 2'd0, 32'hA5A5_A5A5, 32'h1234_5678, 32'h1234_5678};

    // ---- reset state
    do_reset();
    smp();
    chk("rst_wb_valid", bus.mem_wb_valid, 1'b0);
    chk("rst_allowin", bus.mem_allowin, 1'b1);
    chk("rst_fwd_we", bus.mem_fwd_we, 1'b0);
    chk("rst_fwd_stall", bus.mem_fwd_stall, 1'b0);
    chk("rst_mem_ex", bus.mem_ex, 1'b0);
    chk("rst_mem_ertn", bus.mem_ertn, 1'b0);
    step();

    // ---- table: alignment / extension, response in the cycle after issue
    for (int k = 0; k < 10; k++) begin
      if (vecs[k].ld) li = mk_load(vecs[k].typ, vecs[k].a, 5'd7, 32'h100 + 32'(k * 4));
      else            li = mk_alu(5'd7, 32'h100 + 32'(k * 4), vecs[k].alu);
      drive_ins(li, 1'b1);
      smp();
      chk($sformatf("vec%0d_allowin", k), bus.mem_allowin, 1'b1);
      step();
      bus.ex_mem_valid      = 1'b0;
      bus.data_sram_data_ok = vecs[k].ld;
      bus.data_sram_rdata   = vecs[k].rdata;
      smp();
      chk($sformatf("vec%0d_wb_valid", k), bus.mem_wb_valid, 1'b1);
      chk($sformatf("vec%0d_result", k), bus.mem_wb_result, vecs[k].exp);
      chk($sformatf("vec%0d_fwd_stall", k), bus.mem_fwd_stall, 1'b0);
      step();
      bus.data_sram_data_ok = 1'b0;
    end

    // ---- load with late response and WB back-pressure
    do_reset();
    drive_ins(mk_load(3'b011, 2'd0, 5'd9, 32'h200), 1'b1);
    step();
    bus.ex_mem_valid = 1'b0;
    bus.wb_allowin   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("late%0d_stall", k), bus.mem_fwd_stall, 1'b1);
      chk($sformatf("late%0d_wb_valid", k), bus.mem_wb_valid, 1'b0);
      chk($sformatf("late%0d_allowin", k), bus.mem_allowin, 1'b0);
      step();
    end
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hCAFE_F00D;
    smp();
    chk("late_dataok_stall", bus.mem_fwd_stall, 1'b0);
    chk("late_dataok_wb_valid", bus.mem_wb_valid, 1'b1);
    chk("late_dataok_allowin", bus.mem_allowin, 1'b0);
    chk("late_dataok_fwd_data", bus.mem_fwd_data, 32'hCAFE_F00D);
    step();
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h0;
    bus.wb_allowin        = 1'b1;
    smp();
    chk("late_buf_wb_valid", bus.mem_wb_valid, 1'b1);
    chk("late_buf_result", bus.mem_wb_result, 32'hCAFE_F00D);
    chk("late_buf_allowin", bus.mem_allowin, 1'b1);
    step();
    smp();
    chk("late_after_wb_valid", bus.mem_wb_valid, 1'b0);
    step();

    // ---- flush while waiting: the stale response must be absorbed
    do_reset();
    drive_ins(mk_load(3'b000, 2'd0, 5'd3, 32'h300), 1'b1);
    step();
    bus.ex_mem_valid = 1'b0;
    bus.wb_flush     = 1'b1;
    smp();
    chk("flush_wb_valid", bus.mem_wb_valid, 1'b0);
    step();
    bus.wb_flush = 1'b0;
    drive_ins(mk_load(3'b011, 2'd0, 5'd4, 32'h304), 1'b1);
    smp();
    chk("flush_after_wb_valid", bus.mem_wb_valid, 1'b0);
    chk("flush_after_allowin", bus.mem_allowin, 1'b1);
    chk("flush_after_fwd_we", bus.mem_fwd_we, 1'b0);
    step();
    bus.ex_mem_valid      = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h1111_1111;
    smp();
    chk("stale_wb_valid", bus.mem_wb_valid, 1'b0);
    chk("stale_fwd_stall", bus.mem_fwd_stall, 1'b1);
    step();
    bus.data_sram_rdata = 32'h2222_2222;
    smp();
    chk("own_wb_valid", bus.mem_wb_valid, 1'b1);
    chk("own_result", bus.mem_wb_result, 32'h2222_2222);
    step();
    bus.data_sram_data_ok = 1'b0;

    // ---- four back-to-back non-memory instrs
    do_reset();
    xfers = 0;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) drive_ins(mk_alu(5'd10, 32'h400 + 32'(k * 4), 32'h1000 + 32'(k)), 1'b1);
      else       bus.ex_mem_valid = 1'b0;
      smp();
      chk($sformatf("b2b%0d_allowin", k), bus.mem_allowin, 1'b1);
      if (k > 0) begin
        chk($sformatf("b2b%0d_result", k), bus.mem_wb_result, 32'h1000 + 32'(k - 1));
        chk($sformatf("b2b%0d_pc", k), bus.mem_wb_pc, 32'h400 + 32'((k - 1) * 4));
      end
      if (bus.mem_wb_valid && bus.wb_allowin) xfers++;
      step();
    end
    smp();
    if (bus.mem_wb_valid && bus.wb_allowin) xfers++;
    chk("b2b_xfers", 32'(xfers), 32'd4);
    step();

    // ---- synchronous reset in WAIT with a pending discard
    do_reset();
    drive_ins(mk_load(3'b011, 2'd0, 5'd5, 32'h500), 1'b1);
    step();
    bus.ex_mem_valid = 1'b0;
    bus.wb_flush     = 1'b1;
    step();
    bus.wb_flush = 1'b0;
    drive_ins(mk_load(3'b011, 2'd0, 5'd5, 32'h504), 1'b1);
    step();
    bus.ex_mem_valid = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    smp();
    chk("rstw_wb_valid", bus.mem_wb_valid, 1'b0);
    chk("rstw_fwd_we", bus.mem_fwd_we, 1'b0);
    chk("rstw_fwd_stall", bus.mem_fwd_stall, 1'b0);
    chk("rstw_mem_ex", bus.mem_ex, 1'b0);
    chk("rstw_mem_ertn", bus.mem_ertn, 1'b0);
    step();
    drive_ins(mk_load(3'b011, 2'd0, 5'd6, 32'h508), 1'b1);
    step();
    bus.ex_mem_valid      = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h3333_3333;
    smp();
    chk("rstw_cnt_clear_wb_valid", bus.mem_wb_valid, 1'b1);
    chk("rstw_cnt_clear_result", bus.mem_wb_result, 32'h3333_3333);
    step();

    // ---- randomized run against a transaction-level model
    do_reset();
    pend.delete();
    m_valid = 1'b0; m_need = 1'b0; m_have = 1'b0; m_data = '0;
    m_ins = mk_alu(5'd0, 32'h0, 32'h0);
    cur = gen_ins(); cur_v = 1'b0; last_taken = 1'b0; last_flush = 1'b0;
    xfers = 0;
    for (int n = 0; n < 4000; n++) begin
      if (!cur_v || last_taken || last_flush) begin
        cur   = gen_ins();
        cur_v = ($urandom_range(0, 3) != 0);
      end
      d_ok  = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      rdata = $urandom;
      wba   = ($urandom_range(0, 3) != 0);
      flush = (pend.size() <= 1) && ($urandom_range(0, 15) == 0);
      drive_ins(cur, cur_v);
      bus.data_sram_data_ok = d_ok;
      bus.data_sram_rdata   = rdata;
      bus.wb_allowin        = wba;
      bus.wb_flush          = flush;
      smp();

      resp_live = d_ok && pend.size() > 0 && pend[0];
      done      = !m_need || m_have || resp_live;
      e_wbv     = m_valid && done && !flush;
      e_allow   = !m_valid || (done && wba);
      e_fwe     = m_valid && m_ins.gr_we && !m_ins.excp && (m_ins.dest != 5'd0);
      e_stall   = e_fwe && m_ins.res && !done;
      ldata     = m_have ? m_data : rdata;
      e_res     = m_ins.res ? ref_load(ldata, m_ins.typ, m_ins.a) : m_ins.alu;

      chk($sformatf("rnd%0d_wb_valid", n), bus.mem_wb_valid, e_wbv);
      chk($sformatf("rnd%0d_allowin", n), bus.mem_allowin, e_allow);
      chk($sformatf("rnd%0d_fwd_we", n), bus.mem_fwd_we, e_fwe);
      chk($sformatf("rnd%0d_fwd_stall", n), bus.mem_fwd_stall, e_stall);
      chk($sformatf("rnd%0d_mem_ex", n), bus.mem_ex, m_valid && m_ins.excp);
      chk($sformatf("rnd%0d_mem_ertn", n), bus.mem_ertn, m_valid && m_ins.ertn);
      if (e_fwe && !e_stall) begin
        chk($sformatf("rnd%0d_fwd_dest", n), bus.mem_fwd_dest, m_ins.dest);
        chk($sformatf("rnd%0d_fwd_data", n), bus.mem_fwd_data, e_res);
      end
      if (e_wbv && wba) begin
        xfers++;
        chk($sformatf("rnd%0d_wb_pc", n), bus.mem_wb_pc, m_ins.pc);
        chk($sformatf("rnd%0d_wb_result", n), bus.mem_wb_result, e_res);
        chk($sformatf("rnd%0d_wb_gr_we", n), bus.mem_wb_gr_we, m_ins.gr_we);
        chk($sformatf("rnd%0d_wb_dest", n), bus.mem_wb_dest, m_ins.dest);
        chk($sformatf("rnd%0d_wb_excp", n), bus.mem_wb_excp, m_ins.excp);
        chk($sformatf("rnd%0d_wb_ertn", n), bus.mem_wb_ertn, m_ins.ertn);
      end

      // every response, live or cancelled, retires the oldest request
      if (d_ok) void'(pend.pop_front());
      last_taken = 1'b0;
      last_flush = flush;
      if (flush) begin
        foreach (pend[k]) pend[k] = 1'b0;
        if (cur_v && e_allow && cur.req) pend.push_back(1'b0);
        m_valid = 1'b0;
        m_have  = 1'b0;
      end else if (e_allow) begin
        m_valid    = cur_v;
        last_taken = cur_v;
        if (cur_v) begin
          m_ins  = cur;
          m_need = cur.req && !cur.excp;
          m_have = 1'b0;
          if (cur.req) pend.push_back(1'b1);
        end
      end else if (resp_live) begin
        m_have = 1'b1;
        m_data = rdata;
      end
      step();
    end
    chk("rnd_xfers_seen", 32'(xfers > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
